// File: rtl/mdu_controller_pkg.sv
// rtl/mdu_controller_pkg.sv - shared op/state encodings and default latencies for the MDU
package mdu_controller_pkg;

  localparam logic [1:0] MDU_OP_MULT  = 2'b00;
  localparam logic [1:0] MDU_OP_MULTU = 2'b01;
  localparam logic [1:0] MDU_OP_DIV   = 2'b10;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU
module mdu_arith
  import mdu_controller_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result
);

  logic [63:0] a_sext, b_sext;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_sgn, r_sgn;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    a_sext = {{32{src_a[31]}}, src_a};
    b_sext = {{32{src_b[31]}}, src_b};
    a_mag  = src_a[31] ? (~src_a + 32'd1) : src_a;
    b_mag  = src_b[31] ? (~src_b + 32'd1) : src_b;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    q_sgn  = (src_a[31] ^ src_b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_sgn  = src_a[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    result = 64'd0;
    case (op)
      MDU_OP_MULT:  result = a_sext * b_sext;
      MDU_OP_MULTU: result = {32'd0, src_a} * {32'd0, src_b};
      MDU_OP_DIV:   result = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF} : {r_sgn, q_sgn};
      MDU_OP_DIVU:  result = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF}
                                              : {src_a % src_b, src_a / src_b};
      default:      result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// rtl/mdu_controller.sv - multi-cycle MDU sequencer with HI/LO and D-stage stall; MDU_DIVZERO_KEEP_EN skips divide-by-zero
module mdu_controller
  import mdu_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wd,
  input  logic        md_instr_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] result;
  logic        skip_launch;

`ifdef MDU_DIVZERO_KEEP_EN
  assign skip_launch = op[1] & (src_b == 32'd0);
`else
  assign skip_launch = 1'b0;
`endif

  mdu_arith u_arith (
    .op     (op_q),
    .src_a  (a_q),
    .src_b  (b_q),
    .result (result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        // A start always swallows a same-cycle mthi/mtlo, even when the launch is skipped.
        if (start) begin
          if (!skip_launch) begin
            state_d = MDU_BUSY;
            cnt_d   = op[1] ? DIV_LAT : MULT_LAT;
            op_d    = op;
            a_d     = src_a;
            b_d     = src_b;
          end
        end else begin
          if (mthi) hi_d = wd;
          if (mtlo) lo_d = wd;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = MDU_IDLE;
          hi_d    = result[63:32];
          lo_d    = result[31:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MDU_OP_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == MDU_BUSY);
  assign stall = md_instr_d & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// tb/tb_mdu_controller.sv - directed bench with cycle model and literal expectations; honours MDU_DIVZERO_KEEP_EN
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wd;
  logic        mthi, mtlo, md_instr_d;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wd         (wd),
    .md_instr_d (md_instr_d),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus the pending 64-bit result.
  int          m_left = 0;
  logic [63:0] m_res  = 64'd0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'd0:    return 64'(sa * sb);
      2'd1:    return 64'(ua * ub);
      2'd2:    begin sq = sa / sb; sr = sa % sb; return {sr[31:0], sq[31:0]}; end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_hi = m_res[63:32]; m_lo = m_res[31:0]; end
    end else if (start) begin
`ifdef MDU_DIVZERO_KEEP_EN
      if (!(op[1] && src_b == 32'd0)) begin
`else
      begin
`endif
        m_left = op[1] ? 10 : 5;
        m_res  = ref_result(op, src_a, src_b);
      end
    end else begin
      if (mthi) m_hi = wd;
      if (mtlo) m_lo = wd;
    end
  end

  always @(negedge clk) begin
    chk("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("model_stall", {31'd0, stall}, {31'd0, md_instr_d & ((m_left > 0) | start)});
    chk("model_hi", hi, m_hi);
    chk("model_lo", lo, m_lo);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic with_mthi);
    start = 1'b1; op = o; src_a = a; src_b = b; md_instr_d = 1'b1;
    mthi = with_mthi; wd = 32'h0000_1234;
    #1 chk({name, "_stall_start"}, {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0; mthi = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk({name, "_done"}, {31'd0, busy}, 32'd0);
    chk({name, "_stall_end"}, {31'd0, stall}, 32'd0);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wd = 32'd0; md_instr_d = 1'b1;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    start = 1'b0; md_instr_d = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    run_op("mult",  2'd0, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   2'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",  2'd3, 32'd7,         32'd2,         10, 32'd1,         32'd3,         1'b0);
    run_op("divov", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000, 1'b0);
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'd1,         1'b0);
    run_op("mthi_start", 2'd1, 32'd2,    32'd3,         5,  32'd0,         32'd6,         1'b1);

    mtlo = 1'b1; wd = 32'h0000_0055; md_instr_d = 1'b0;
    tick();
    mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_hi", hi, 32'd0);
    tick();

    start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd1; mthi = 1'b1; wd = 32'h0000_DEAD;
    tick();
    start = 1'b0; mthi = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_hi", hi, 32'hFFFF_FFFF);
    chk("ign_lo", lo, 32'hFFFF_FFF9);
    tick();

`ifdef MDU_DIVZERO_KEEP_EN
    start = 1'b1; op = 2'd3; src_a = 32'd5; src_b = 32'd0; md_instr_d = 1'b1;
    #1 chk("dz_stall", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_stall_after", {31'd0, stall}, 32'd0);
    chk("dz_hi", hi, 32'hFFFF_FFFF);
    chk("dz_lo", lo, 32'hFFFF_FFF9);
    tick();
`else
    run_op("dz", 2'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 1'b0);
`endif

    start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("arst_nocommit_busy", {31'd0, busy}, 32'd0);
    chk("arst_nocommit_hi", hi, 32'd0);
    chk("arst_nocommit_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage request to launch a multiply/divide.
REQ-006 op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 src_a  input  32  rs operand (dividend / multiplicand).
REQ-008 src_b  input  32  rt operand (divisor / multiplier).
REQ-009 mthi, mtlo  input  1 each  E-stage writes of wd into HI / LO.
REQ-010 wd  input  32  write data for mthi/mtlo.
REQ-011 md_instr_d  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-012 busy  output  1  operation in flight.
REQ-013 stall  output  1  D-stage stall request to the hazard unit.
REQ-014 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 FSM: IDLE and BUSY only; the cycle counter is 4 bits.
REQ-016 In IDLE, start=1 at an edge loads the counter with MULT_CYCLES or DIV_CYCLES, latches op and operands, and enters BUSY.
REQ-017 In BUSY, the counter decrements every edge; the edge taking it from 1 to 0 commits the result to HI/LO and returns to IDLE in the same edge.
REQ-018 busy is high for exactly N cycles after the start edge (N = selected latency); new HI/LO are visible in the first cycle busy is low.
REQ-019 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-020 DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend; DIVU: unsigned quotient/remainder.
REQ-021 DIV with 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-022 stall = md_instr_d & (busy | start), combinational.
REQ-023 start, mthi and mtlo are ignored while busy=1; hi/lo hold their values during BUSY.
REQ-024 In IDLE, mthi/mtlo write wd at the edge. If start and mthi/mtlo are asserted together, start wins and the write is dropped.
REQ-025 Divide-by-zero without the feature of REQ-029: normal latency; lo=0xFFFFFFFF, hi=dividend.

Reset
REQ-026 reset_n=0 forces IDLE, counter=0, busy=0, hi=0, lo=0 immediately, independent of clk.
REQ-027 Reset during BUSY aborts the operation and no commit occurs.
REQ-028 stall is combinational and depends only on inputs and busy, so stall equals md_instr_d & start while in reset.

Configuration
REQ-029 Macro MDU_DIVZERO_KEEP_EN is the only compile-time feature switch.
REQ-030 With MDU_DIVZERO_KEEP_EN defined, DIV/DIVU with src_b=0 does not enter BUSY: hi/lo are unchanged, busy stays 0, and stall follows REQ-022.
REQ-031 Without MDU_DIVZERO_KEEP_EN, REQ-025 applies.

Structure
REQ-032 The shared package/header holds: op encodings MDU_OP_MULT/MULTU/DIV/DIVU, state encodings MDU_IDLE/MDU_BUSY, and default latency constants.
REQ-033 A single sub-module, mdu_arith, computes the combinational 64-bit result from op and the latched operands; mdu_controller owns the FSM, counter, HI/LO and stall.

Verification
REQ-034 MULT 0xFFFFFFFE * 3 at edge 0 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 DIV 0xFFFFFFF9 / 2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
REQ-036 md_instr_d=1 with start=1 and throughout BUSY -> stall=1 in every one of those cycles; stall=0 in the cycle busy falls.
REQ-037 mthi 0x1234 and start in the same cycle -> the operation runs and the final hi equals the operation result, not 0x1234; mtlo 0x55 in IDLE -> lo=0x55 next cycle.
REQ-038 DIVU 5/0 -> with the macro: busy=0, hi/lo unchanged; without the macro: after 10 cycles lo=0xFFFFFFFF, hi=5.
REQ-039 reset_n pulsed low in cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately, with no later commit.
